imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write side of the byte-addressed, little-endian instruction memory: accepts a program as a byte stream over a valid/ready handshake and writes it into an internal 256-byte array.
- Exposes the CPU fetch port: a 32-bit address in, the assembled instruction word out.
- Used to (re)program the pipeline CPU at run time instead of initialising memory from a file.
- Asserts busy so the CPU can be held in reset while loading.

Parameters:
- DEPTH, 256, memory size in bytes; must be a power of 2.
- AW, 8, byte-address width, log2(DEPTH).
- LW, 16, width of the load length field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base  in  AW  first byte address of the load; sampled with start.
- len  in  LW  number of bytes to load; sampled with start.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- busy  out  1  load in progress (state != IDLE).
- done  out  1  one-cycle pulse when the load completes.
- sum  out  8  running modulo-256 sum of the accepted bytes of the current load.
- addr  in  32  CPU fetch byte address.
- IR  out  32  {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}, combinational.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; in_ready=0, busy=0, done=0, sum=0; internal ptr=0, remaining=0.
  - Memory contents are not cleared.
- FSM states:
  - IDLE:
    - start=1, len=0: go to DONE, no writes, sum<=0.
    - start=1, len!=0: ptr<=base, remaining<=len, sum<=0, go to LOAD.
  - LOAD:
    - in_ready=1 (registered state decode, no combinational path from in_valid).
    - A byte is accepted on a cycle with in_valid & in_ready. On acceptance: mem[ptr]<=in_data, ptr<=ptr+1 mod DEPTH, remaining<=remaining-1, sum<=sum+in_data mod 256.
    - Acceptance with remaining==1: go to DONE.
    - in_valid=0: hold all state; gaps of any length are allowed.
  - DONE:
    - done=1 for exactly this one cycle, in_ready=0; next state IDLE.
- start while in LOAD or DONE is ignored. in_valid while in IDLE or DONE is not consumed (in_ready=0).
- Latency: done is high in the cycle after the last byte is accepted. After a start with len=0, done is high in the cycle after start.
- Wrap-around: ptr wraps from DEPTH-1 to 0. len > DEPTH overwrites earlier bytes in order; the last write wins.
- Fetch port:
  - Uses addr[AW-1:0]; byte indices addr+k are taken modulo DEPTH.
  - No alignment requirement.
  - A write at a clock edge is visible on IR after that edge. In the same cycle as the write, IR shows the old byte.
- Reset mid-LOAD: abort to IDLE with no done pulse; bytes already written remain in memory.
- Simultaneous rst and start: rst wins.
- busy stays high from the cycle after start through the DONE cycle inclusive.

Decomposition:
- Shared package imem_pkg:
  - state enum {IDLE, LOAD, DONE}.
  - IMEM_DEPTH=256, IMEM_AW=8 constants, also shared by the CPU fetch stage.
- Sub-module imem_byte_ram:
  - DEPTH x 8 array with one synchronous byte-write port (we, waddr, wdata).
  - Combinational 4-byte little-endian read port with modulo-DEPTH indexing.
- imem_loader holds the FSM, ptr, remaining and sum, and instantiates imem_byte_ram.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, busy=0, done=0, sum=0 after release; no memory writes.
2. Basic load:
   - Stimulus: start base=0 len=4; bytes 0x34,0x12,0x08,0x3C sent back-to-back.
   - Required: done pulses once, one cycle after the 4th byte is accepted; sum=0x8A; addr=0 gives IR=0x3C081234.
3. Backpressure/gaps:
   - Stimulus: same load as scenario 2, with in_valid low for 3 cycles between bytes 2 and 3.
   - Required: identical memory contents and sum=0x8A; no extra writes during the gaps.
4. Wrap-around:
   - Stimulus: base=254 len=4, bytes 0x11,0x22,0x33,0x44.
   - Required: mem[254]=0x11, mem[255]=0x22, mem[0]=0x33, mem[1]=0x44; addr=254 gives IR=0x44332211.
5. Zero length and ignored start:
   - len=0 start -> done high in the next cycle, busy high for 1 cycle, memory unchanged.
   - start pulsed mid-LOAD with a different base -> ignored; the load completes at the original addresses.
6. Reset mid-load:
   - Stimulus: base=16 len=4; rst after 2 of the bytes 0xAA,0xBB,0xCC,0xDD are accepted.
   - Required: no done pulse, state IDLE, in_ready=0; mem[16]=0xAA, mem[17]=0xBB; mem[18] and mem[19] keep their prior values.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: loader FSM states and the memory
// geometry that both the loader and the CPU fetch stage agree on.
package imem_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;
  localparam int IMEM_LW    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide instruction RAM: one synchronous byte write port and a
// combinational little-endian 32-bit read port. Read indices wrap modulo
// DEPTH so an instruction may straddle the top of memory.
module imem_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx1;
  logic [AW-1:0] idx2;
  logic [AW-1:0] idx3;

  // Contents are deliberately not reset so a reset never destroys a program.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // AW-bit additions give the modulo-DEPTH wrap for free.
  always_comb begin
    idx1  = raddr + AW'(1);
    idx2  = raddr + AW'(2);
    idx3  = raddr + AW'(3);
    rdata = {mem[idx3], mem[idx2], mem[idx1], mem[raddr]};
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a program as a valid/ready byte stream,
// writes it into a byte RAM starting at a chosen base address, and exposes a
// combinational 32-bit fetch port for the CPU. busy lets the CPU be held in
// reset while a new program is streamed in.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int LW    = IMEM_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    sum,
  input  logic [31:0]   addr,
  output logic [31:0]   IR
);

  imem_state_t   state;
  imem_state_t   state_next;
  logic [AW-1:0] ptr;
  logic [LW-1:0] remaining;
  logic          accept;
  logic          we;
  logic          unused_addr_hi;

  // A byte is consumed only while loading; reset takes priority over a write.
  assign accept = in_valid & in_ready;
  assign we     = accept & ~rst;

  // The fetch port only decodes the low byte-address bits.
  assign unused_addr_hi = ^addr[31:AW];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && (remaining == LW'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state only, so in_ready never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Load bookkeeping: capture base/len on start, advance per accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum <= '0;
            if (len != '0) begin
              ptr       <= base;
              remaining <= len;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            ptr       <= ptr + AW'(1);
            remaining <= remaining - LW'(1);
            sum       <= sum + in_data;
          end
        end
        default: begin
          ptr <= ptr;
        end
      endcase
    end
  end

  imem_byte_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(ptr),
    .wdata(in_data),
    .raddr(addr[AW-1:0]),
    .rdata(IR)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A byte-array model of the memory and a
// running-sum model are updated from the stream rules as bytes are accepted.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base;
  logic [15:0] len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [7:0]  sum;
  logic [31:0] addr;
  logic [31:0] IR;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] data_q [$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .len     (len),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .addr    (addr),
    .IR      (IR)
  );

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    return {model[(b + 3) % 256], model[(b + 2) % 256], model[(b + 1) % 256], model[b]};
  endfunction

  // Sweep every byte address (random upper address bits) against the model.
  task automatic check_memory(input string name);
    logic [31:0] exp;
    for (int a = 0; a < 256; a++) begin
      addr = ($urandom() & 32'hFFFF_FF00) | 32'(a);
      #1;
      exp = model_word(addr);
      checks++;
      if (IR !== exp) begin
        errors++;
        $display("[TB] FAIL %s mem addr=%h: got %h expected %h", name, addr, IR, exp);
      end
    end
  endtask

  // Drive one complete load of data_q[0..n-1] and check it cycle by cycle.
  task automatic run_load(input string name, input logic [7:0] b, input int n,
                          input bit rand_gaps, input int gap_at, input int gap_len,
                          input bit mid_start);
    int i, cycles, budget, gapped;
    bit acc;
    logic [7:0] exp_sum, last;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL %s idle status: got %b expected 000", name, {in_ready, busy, done});
    end
    start = 1'b1; base = b; len = 16'(n);
    @(negedge clk);
    start = 1'b0; base = 8'($urandom()); len = 16'($urandom());
    i = 0; cycles = 0; gapped = 0; acc = 1'b0; exp_sum = 8'h00; last = 8'h00;
    budget = n * 4 + gap_len + 20;
    while (i < n && cycles < budget) begin
      if (acc) begin
        checks++;
        if (IR[7:0] !== last) begin
          errors++;
          $display("[TB] FAIL %s new byte visible: got %h expected %h", name, IR[7:0], last);
        end
      end
      checks++;
      if ({in_ready, busy, done} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL %s load status: got %b expected 110", name, {in_ready, busy, done});
      end
      checks++;
      if (sum !== exp_sum) begin
        errors++;
        $display("[TB] FAIL %s running sum: got %h expected %h", name, sum, exp_sum);
      end
      start = mid_start && (cycles == 1);
      base  = b ^ 8'h80;
      len   = 16'd3;
      if (i == gap_at && gapped < gap_len) begin
        acc = 1'b0;
        gapped++;
      end else begin
        acc = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (acc) begin
        in_valid = 1'b1;
        in_data  = data_q[i];
        addr     = ($urandom() & 32'hFFFF_FF00) | 32'((int'(b) + i) % 256);
        #1;
        checks++;
        if (IR[7:0] !== model[(int'(b) + i) % 256]) begin
          errors++;
          $display("[TB] FAIL %s old byte before write: got %h expected %h", name, IR[7:0],
                   model[(int'(b) + i) % 256]);
        end
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom());
      end
      @(negedge clk);
      if (acc) begin
        last = data_q[i];
        model[(int'(b) + i) % 256] = data_q[i];
        exp_sum = 8'((int'(exp_sum) + int'(data_q[i])) % 256);
        i++;
      end
      cycles++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: accepted %0d expected %0d", name, i, n);
    end
    if (acc) begin
      checks++;
      if (IR[7:0] !== last) begin
        errors++;
        $display("[TB] FAIL %s last byte visible: got %h expected %h", name, IR[7:0], last);
      end
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL %s done cycle status: got %b expected 011", name, {in_ready, busy, done});
    end
    checks++;
    if (sum !== exp_sum) begin
      errors++;
      $display("[TB] FAIL %s final sum: got %h expected %h", name, sum, exp_sum);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done} !== 3'b000 || sum !== exp_sum) begin
        errors++;
        $display("[TB] FAIL %s after done: got status %b sum %h expected 000 sum %h", name,
                 {in_ready, busy, done}, sum, exp_sum);
      end
    end
  endtask

  task automatic test_reset(input string name, input bit with_mem);
    rst = 1'b1; start = 1'b1; base = 8'h40; len = 16'd5;
    in_valid = 1'b1; in_data = 8'($urandom());
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b000 || sum !== 8'h00) begin
      errors++;
      $display("[TB] FAIL %s during reset: got status %b sum %h expected 000 sum 00", name,
               {in_ready, busy, done}, sum);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done} !== 3'b000 || sum !== 8'h00) begin
        errors++;
        $display("[TB] FAIL %s after reset: got status %b sum %h expected 000 sum 00", name,
                 {in_ready, busy, done}, sum);
      end
    end
    in_valid = 1'b0;
    if (with_mem) check_memory(name);
  endtask

  task automatic test_fill();
    data_q.delete();
    for (int k = 0; k < 256; k++) data_q.push_back(8'($urandom()));
    run_load("fill", 8'($urandom()), 256, 1'b1, -1, 0, 1'b0);
    check_memory("fill");
  endtask

  task automatic test_basic();
    data_q = '{8'h34, 8'h12, 8'h08, 8'h3C};
    run_load("basic", 8'd0, 4, 1'b0, -1, 0, 1'b0);
    checks++;
    if (sum !== 8'h8A) begin
      errors++;
      $display("[TB] FAIL basic sum: got %h expected 8a", sum);
    end
    addr = 32'h0; #1;
    checks++;
    if (IR !== 32'h3C081234) begin
      errors++;
      $display("[TB] FAIL basic IR: got %h expected 3c081234", IR);
    end
  endtask

  task automatic test_gaps();
    data_q = '{8'h5A, 8'hA5, 8'hC3, 8'h3C ^ 8'hFF};
    run_load("gaps_pre", 8'd0, 4, 1'b0, -1, 0, 1'b0);
    data_q = '{8'h34, 8'h12, 8'h08, 8'h3C};
    run_load("gaps", 8'd0, 4, 1'b0, 2, 3, 1'b0);
    checks++;
    if (sum !== 8'h8A) begin
      errors++;
      $display("[TB] FAIL gaps sum: got %h expected 8a", sum);
    end
    addr = 32'h0; #1;
    checks++;
    if (IR !== 32'h3C081234) begin
      errors++;
      $display("[TB] FAIL gaps IR: got %h expected 3c081234", IR);
    end
    check_memory("gaps");
  endtask

  task automatic test_wrap();
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load("wrap", 8'd254, 4, 1'b0, -1, 0, 1'b0);
    addr = 32'd254; #1;
    checks++;
    if (IR !== 32'h44332211) begin
      errors++;
      $display("[TB] FAIL wrap IR@254: got %h expected 44332211", IR);
    end
    addr = 32'h0000_0100; #1;
    checks++;
    if (IR[15:0] !== 16'h4433) begin
      errors++;
      $display("[TB] FAIL wrap IR@0 low half: got %h expected 4433", IR[15:0]);
    end
    check_memory("wrap");
  endtask

  task automatic test_zero_len();
    data_q.delete();
    run_load("zero_len", 8'($urandom()), 0, 1'b0, -1, 0, 1'b0);
    checks++;
    if (sum !== 8'h00) begin
      errors++;
      $display("[TB] FAIL zero_len sum: got %h expected 00", sum);
    end
    check_memory("zero_len");
  endtask

  task automatic test_ignored_start();
    data_q.delete();
    for (int k = 0; k < 6; k++) data_q.push_back(8'($urandom()));
    run_load("ignored_start", 8'h20, 6, 1'b0, -1, 0, 1'b1);
    check_memory("ignored_start");
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start = 1'b1; base = 8'd16; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    model[16] = 8'hAA;
    in_data = 8'hBB;
    @(negedge clk);
    model[17] = 8'hBB;
    rst = 1'b1; in_data = 8'hCC;
    @(negedge clk);
    rst = 1'b0; in_data = 8'hDD;
    repeat (2) begin
      checks++;
      if ({in_ready, busy, done} !== 3'b000 || sum !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_mid_load status: got %b sum %h expected 000 sum 00",
                 {in_ready, busy, done}, sum);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    addr = 32'd16; #1;
    checks++;
    if (IR[15:0] !== 16'hBBAA) begin
      errors++;
      $display("[TB] FAIL reset_mid_load IR@16: got %h expected bbaa", IR[15:0]);
    end
    check_memory("reset_mid_load");
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = (t == 5) ? 260 : int'($urandom_range(1, 24));
      data_q.delete();
      for (int k = 0; k < n; k++) data_q.push_back(8'($urandom()));
      run_load("random", 8'($urandom()), n, 1'b1, -1, 0, 1'b0);
    end
    check_memory("random");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = 8'h00; len = 16'h0;
    in_valid = 1'b0; in_data = 8'h00; addr = 32'h0;
    test_reset("reset", 1'b0);
    test_fill();
    test_reset("reset_mem", 1'b1);
    test_basic();
    test_gaps();
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
